// File: rtl/banked_address_generation_unit_pkg.sv
// +--------------------------------------------------------------------------+
// | agu_pkg                                                                  |
// | Shared defaults, derived field widths and pointer-select encodings for   |
// | the banked address generation unit.                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package agu_pkg;

  localparam int ADDR_DEFAULT  = 7;
  localparam int LADDR_DEFAULT = 4;

  localparam logic [1:0] PTR_SEL_PTR = 2'd0;
  localparam logic [1:0] PTR_SEL_LO  = 2'd1;
  localparam logic [1:0] PTR_SEL_HI  = 2'd2;
  localparam logic [1:0] PTR_SEL_RSV = 2'd3;

  function automatic int ofs_width(input int laddr);
    return laddr - 1;
  endfunction

  function automatic int seg_width(input int addr, input int laddr);
    return addr - (laddr - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/banked_address_generation_unit_if.sv
// +--------------------------------------------------------------------------+
// | banked_address_generation_unit_if                                        |
// | Local-address, segment/pointer control and physical-address bundle.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface banked_address_generation_unit_if
  import agu_pkg::*;
#(
  parameter int ADDR  = ADDR_DEFAULT,
  parameter int LADDR = LADDR_DEFAULT
);
  localparam int SEGW = seg_width(ADDR, LADDR);

  logic [LADDR-1:0] l_r_addr_a;
  logic [LADDR-1:0] l_r_addr_b;
  logic [LADDR-1:0] l_w_addr;
  logic             ind_a;
  logic             ind_b;
  logic             ind_w;
  logic             sr_we;
  logic [SEGW-1:0]  sr_wdata;
  logic             sr_inc;
  logic             sr_dec;
  logic             ptr_we;
  logic [1:0]       ptr_sel;
  logic [ADDR-1:0]  ptr_wdata;
  logic             ptr_step;
  logic [ADDR-1:0]  r_addr_a;
  logic [ADDR-1:0]  r_addr_b;
  logic [ADDR-1:0]  w_addr;
  logic [SEGW-1:0]  sr_value;
  logic [ADDR-1:0]  ptr_value;
  logic             ptr_wrap;

  modport master (
    output l_r_addr_a, l_r_addr_b, l_w_addr, ind_a, ind_b, ind_w,
    output sr_we, sr_wdata, sr_inc, sr_dec,
    output ptr_we, ptr_sel, ptr_wdata, ptr_step,
    input  r_addr_a, r_addr_b, w_addr, sr_value, ptr_value, ptr_wrap
  );

  modport slave (
    input  l_r_addr_a, l_r_addr_b, l_w_addr, ind_a, ind_b, ind_w,
    input  sr_we, sr_wdata, sr_inc, sr_dec,
    input  ptr_we, ptr_sel, ptr_wdata, ptr_step,
    output r_addr_a, r_addr_b, w_addr, sr_value, ptr_value, ptr_wrap
  );

endinterface

`default_nettype wire

// File: rtl/banked_address_generation_unit_port_mux.sv
// +--------------------------------------------------------------------------+
// | agu_port_mux                                                             |
// | Maps one local address to a physical address (banked direct / pointer). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module agu_port_mux
  import agu_pkg::*;
#(
  parameter int ADDR  = ADDR_DEFAULT,
  parameter int LADDR = LADDR_DEFAULT
) (
  input  logic [LADDR-1:0]                 local_addr,
  input  logic                             ind,
  input  logic [seg_width(ADDR, LADDR)-1:0] sr,
  input  logic [ADDR-1:0]                  ptr,
  output logic [ADDR-1:0]                  addr
);
  localparam int OFS  = ofs_width(LADDR);
  localparam int SEGW = seg_width(ADDR, LADDR);

  // Bank bit clear selects the fixed low segment instead of the segment register.
  always_comb begin
    addr = ptr;
    if (!ind) begin
      addr = local_addr[LADDR-1] ? {sr, local_addr[OFS-1:0]}
                                 : {{SEGW{1'b0}}, local_addr[OFS-1:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/banked_address_generation_unit.sv
// +--------------------------------------------------------------------------+
// | banked_address_generation_unit                                           |
// | Segment register, windowed post-increment pointer and three port muxes.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module banked_address_generation_unit
  import agu_pkg::*;
#(
  parameter int ADDR  = ADDR_DEFAULT,
  parameter int LADDR = LADDR_DEFAULT
) (
  input logic                            clk,
  input logic                            reset,
  banked_address_generation_unit_if.slave bus
);
  localparam int SEGW = seg_width(ADDR, LADDR);
  localparam logic [SEGW-1:0] c_sr_one  = {{(SEGW-1){1'b0}}, 1'b1};
  localparam logic [ADDR-1:0] c_ptr_one = {{(ADDR-1){1'b0}}, 1'b1};

  logic [SEGW-1:0] r_sr;
  logic [ADDR-1:0] r_ptr;
  logic [ADDR-1:0] r_lo;
  logic [ADDR-1:0] r_hi;
  logic            r_ptr_wrap;

  logic [SEGW-1:0] w_sr_next;
  logic [ADDR-1:0] w_ptr_next;
  logic            w_load_ptr;
  logic            w_wrap_next;

  assign w_load_ptr = bus.ptr_we && (bus.ptr_sel == PTR_SEL_PTR);

  always_comb begin
    w_sr_next = r_sr;
    if (bus.sr_we) begin
      w_sr_next = bus.sr_wdata;
    end else if (bus.sr_inc ^ bus.sr_dec) begin
      w_sr_next = bus.sr_inc ? r_sr + c_sr_one : r_sr - c_sr_one;
    end
  end

  // Window test is pure equality against the current hi, so loads of lo/hi in
  // the same cycle only affect later steps.
  always_comb begin
    w_ptr_next  = r_ptr;
    w_wrap_next = 1'b0;
    if (w_load_ptr) begin
      w_ptr_next = bus.ptr_wdata;
    end else if (bus.ptr_step) begin
      if (r_ptr == r_hi) begin
        w_ptr_next  = r_lo;
        w_wrap_next = 1'b1;
      end else begin
        w_ptr_next = r_ptr + c_ptr_one;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr       <= '0;
      r_ptr      <= '0;
      r_lo       <= '0;
      r_hi       <= '1;
      r_ptr_wrap <= 1'b0;
    end else begin
      r_sr       <= w_sr_next;
      r_ptr      <= w_ptr_next;
      r_ptr_wrap <= w_wrap_next;
      if (bus.ptr_we && (bus.ptr_sel == PTR_SEL_LO)) r_lo <= bus.ptr_wdata;
      if (bus.ptr_we && (bus.ptr_sel == PTR_SEL_HI)) r_hi <= bus.ptr_wdata;
    end
  end

  agu_port_mux #(.ADDR(ADDR), .LADDR(LADDR)) u_mux_a (
    .local_addr (bus.l_r_addr_a),
    .ind        (bus.ind_a),
    .sr         (r_sr),
    .ptr        (r_ptr),
    .addr       (bus.r_addr_a)
  );

  agu_port_mux #(.ADDR(ADDR), .LADDR(LADDR)) u_mux_b (
    .local_addr (bus.l_r_addr_b),
    .ind        (bus.ind_b),
    .sr         (r_sr),
    .ptr        (r_ptr),
    .addr       (bus.r_addr_b)
  );

  agu_port_mux #(.ADDR(ADDR), .LADDR(LADDR)) u_mux_w (
    .local_addr (bus.l_w_addr),
    .ind        (bus.ind_w),
    .sr         (r_sr),
    .ptr        (r_ptr),
    .addr       (bus.w_addr)
  );

  assign bus.sr_value  = r_sr;
  assign bus.ptr_value = r_ptr;
  assign bus.ptr_wrap  = r_ptr_wrap;

endmodule

`default_nettype wire

// File: tb/tb_banked_address_generation_unit.sv
// +--------------------------------------------------------------------------+
// | tb_banked_address_generation_unit                                        |
// | Directed vector table, reset corner cases and model-checked random run.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_banked_address_generation_unit;
  import agu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  banked_address_generation_unit_if bus ();

  banked_address_generation_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sr_we;
    logic [3:0] sr_wdata;
    logic       sr_inc;
    logic       sr_dec;
    logic       ptr_we;
    logic [1:0] ptr_sel;
    logic [6:0] ptr_wdata;
    logic       ptr_step;
    logic       ind;
    logic [3:0] l_addr;
    logic [6:0] exp_addr;
    logic [3:0] exp_sr;
    logic [6:0] exp_ptr;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[20];

  // Reference state for the random phase
  int m_sr, m_ptr, m_lo, m_hi, m_wrap;

  function automatic vec_t mk(
    input logic sr_we, input logic [3:0] sr_wdata, input logic sr_inc, input logic sr_dec,
    input logic ptr_we, input logic [1:0] ptr_sel, input logic [6:0] ptr_wdata,
    input logic ptr_step, input logic ind, input logic [3:0] l_addr,
    input logic [6:0] exp_addr, input logic [3:0] exp_sr, input logic [6:0] exp_ptr,
    input logic exp_wrap);
    vec_t v;
    v.sr_we = sr_we;   v.sr_wdata = sr_wdata;   v.sr_inc = sr_inc;     v.sr_dec = sr_dec;
    v.ptr_we = ptr_we; v.ptr_sel = ptr_sel;     v.ptr_wdata = ptr_wdata;
    v.ptr_step = ptr_step; v.ind = ind;         v.l_addr = l_addr;
    v.exp_addr = exp_addr; v.exp_sr = exp_sr;   v.exp_ptr = exp_ptr;   v.exp_wrap = exp_wrap;
    return v;
  endfunction

  function automatic int ref_addr(input int l, input bit ind);
    if (ind) return m_ptr;
    if (l >= 8) return m_sr * 8 + (l % 8);
    return l % 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.l_r_addr_a = '0; bus.l_r_addr_b = '0; bus.l_w_addr = '0;
    bus.ind_a = 1'b0; bus.ind_b = 1'b0; bus.ind_w = 1'b0;
    bus.sr_we = 1'b0; bus.sr_wdata = '0; bus.sr_inc = 1'b0; bus.sr_dec = 1'b0;
    bus.ptr_we = 1'b0; bus.ptr_sel = '0; bus.ptr_wdata = '0; bus.ptr_step = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, 'hA, 0, 0, 0, 0, 'h00, 0, 0, 'h5, 'h05, 'hA, 'h00, 0);
    vecs[1]  = mk(0, 'h0, 1, 1, 0, 0, 'h00, 0, 0, 'hE, 'h56, 'hA, 'h00, 0);
    vecs[2]  = mk(1, 'hF, 0, 0, 0, 0, 'h00, 0, 0, 'h8, 'h50, 'hF, 'h00, 0);
    vecs[3]  = mk(0, 'h0, 1, 0, 0, 0, 'h00, 0, 0, 'hF, 'h7F, 'h0, 'h00, 0);
    vecs[4]  = mk(0, 'h0, 0, 1, 0, 0, 'h00, 0, 0, 'hF, 'h07, 'hF, 'h00, 0);
    vecs[5]  = mk(0, 'h0, 0, 0, 1, 1, 'h10, 0, 0, 'h0, 'h00, 'hF, 'h00, 0);
    vecs[6]  = mk(0, 'h0, 0, 0, 1, 2, 'h12, 0, 1, 'h0, 'h00, 'hF, 'h00, 0);
    vecs[7]  = mk(0, 'h0, 0, 0, 1, 0, 'h10, 0, 1, 'h3, 'h00, 'hF, 'h10, 0);
    vecs[8]  = mk(0, 'h0, 0, 0, 0, 0, 'h00, 1, 1, 'h0, 'h10, 'hF, 'h11, 0);
    vecs[9]  = mk(0, 'h0, 0, 0, 0, 0, 'h00, 1, 1, 'h0, 'h11, 'hF, 'h12, 0);
    vecs[10] = mk(0, 'h0, 0, 0, 0, 0, 'h00, 1, 1, 'h0, 'h12, 'hF, 'h10, 1);
    vecs[11] = mk(0, 'h0, 0, 0, 0, 0, 'h00, 0, 1, 'h0, 'h10, 'hF, 'h10, 0);
    vecs[12] = mk(0, 'h0, 0, 0, 1, 0, 'h40, 1, 1, 'h0, 'h10, 'hF, 'h40, 0);
    vecs[13] = mk(0, 'h0, 0, 0, 1, 0, 'h7F, 0, 1, 'h0, 'h40, 'hF, 'h7F, 0);
    vecs[14] = mk(0, 'h0, 0, 0, 0, 0, 'h00, 1, 1, 'h0, 'h7F, 'hF, 'h00, 0);
    vecs[15] = mk(0, 'h0, 0, 0, 1, 3, 'h55, 0, 1, 'h0, 'h00, 'hF, 'h00, 0);
    vecs[16] = mk(0, 'h0, 0, 0, 1, 1, 'h05, 1, 1, 'h0, 'h00, 'hF, 'h01, 0);
    vecs[17] = mk(0, 'h0, 0, 0, 1, 2, 'h01, 1, 1, 'h0, 'h01, 'hF, 'h02, 0);
    vecs[18] = mk(0, 'h0, 0, 0, 1, 0, 'h01, 0, 1, 'h0, 'h02, 'hF, 'h01, 0);
    vecs[19] = mk(0, 'h0, 0, 0, 0, 0, 'h00, 1, 1, 'h0, 'h01, 'hF, 'h05, 1);

    set_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_sr", bus.sr_value, 0);
    chk("reset_ptr", bus.ptr_value, 0);
    chk("reset_wrap", bus.ptr_wrap, 0);
    bus.ind_b = 1'b1;
    bus.l_r_addr_b = 4'hF;
    #1 chk("reset_ind_addr_b", bus.r_addr_b, 0);
    reset = 1'b0;
    bus.ind_b = 1'b0;
    bus.l_r_addr_a = 4'hB;
    bus.l_w_addr = 4'h5;
    #1;
    chk("direct_bank1_a", bus.r_addr_a, 7'h03);
    chk("direct_bank0_w", bus.w_addr, 7'h05);

    // Directed table: address checked before the edge, registers after it
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.sr_we = vecs[i].sr_we;   bus.sr_wdata = vecs[i].sr_wdata;
      bus.sr_inc = vecs[i].sr_inc; bus.sr_dec = vecs[i].sr_dec;
      bus.ptr_we = vecs[i].ptr_we; bus.ptr_sel = vecs[i].ptr_sel;
      bus.ptr_wdata = vecs[i].ptr_wdata; bus.ptr_step = vecs[i].ptr_step;
      bus.ind_a = vecs[i].ind; bus.ind_b = vecs[i].ind; bus.ind_w = vecs[i].ind;
      bus.l_r_addr_a = vecs[i].l_addr; bus.l_r_addr_b = vecs[i].l_addr;
      bus.l_w_addr = vecs[i].l_addr;
      #1;
      chk($sformatf("vec%0d_addr_a", i), bus.r_addr_a, vecs[i].exp_addr);
      chk($sformatf("vec%0d_addr_b", i), bus.r_addr_b, vecs[i].exp_addr);
      chk($sformatf("vec%0d_addr_w", i), bus.w_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_sr", i), bus.sr_value, vecs[i].exp_sr);
      chk($sformatf("vec%0d_ptr", i), bus.ptr_value, vecs[i].exp_ptr);
      chk($sformatf("vec%0d_wrap", i), bus.ptr_wrap, vecs[i].exp_wrap);
    end

    // Asynchronous reset mid-cycle with sr=3, ptr=0x11
    @(negedge clk);
    set_idle();
    bus.sr_we = 1'b1; bus.sr_wdata = 4'h3;
    bus.ptr_we = 1'b1; bus.ptr_sel = PTR_SEL_PTR; bus.ptr_wdata = 7'h11;
    @(negedge clk);
    set_idle();
    chk("pre_reset_sr", bus.sr_value, 4'h3);
    chk("pre_reset_ptr", bus.ptr_value, 7'h11);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_sr", bus.sr_value, 0);
    chk("async_reset_ptr", bus.ptr_value, 0);
    chk("async_reset_wrap", bus.ptr_wrap, 0);

    // Wrap against the reset hi value, then drop the pending pulse by reset
    @(negedge clk);
    reset = 1'b0;
    bus.ptr_we = 1'b1; bus.ptr_sel = PTR_SEL_PTR; bus.ptr_wdata = 7'h7F;
    @(negedge clk);
    set_idle();
    bus.ptr_step = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_hi_wrap_ptr", bus.ptr_value, 0);
    chk("reset_hi_wrap_flag", bus.ptr_wrap, 1);
    bus.ptr_step = 1'b0;
    #1 reset = 1'b1;
    #1 chk("wrap_dropped_by_reset", bus.ptr_wrap, 0);
    @(negedge clk);
    reset = 1'b0;

    m_sr = 0; m_ptr = 0; m_lo = 0; m_hi = 127; m_wrap = 0;
    for (int i = 0; i < 600; i++) begin
      int n_sr, n_ptr, n_lo, n_hi, n_wrap;
      @(negedge clk);
      bus.l_r_addr_a = 4'($urandom); bus.l_r_addr_b = 4'($urandom); bus.l_w_addr = 4'($urandom);
      bus.ind_a = 1'($urandom); bus.ind_b = 1'($urandom); bus.ind_w = 1'($urandom);
      bus.sr_we = ($urandom_range(0, 7) == 0);
      bus.sr_wdata = 4'($urandom);
      bus.sr_inc = 1'($urandom); bus.sr_dec = 1'($urandom);
      bus.ptr_we = ($urandom_range(0, 5) == 0);
      bus.ptr_sel = 2'($urandom);
      bus.ptr_wdata = $urandom_range(0, 1) ? 7'($urandom) : 7'(32 + $urandom_range(0, 5));
      bus.ptr_step = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_addr_a", bus.r_addr_a, ref_addr(int'(bus.l_r_addr_a), bus.ind_a));
      chk("rand_addr_b", bus.r_addr_b, ref_addr(int'(bus.l_r_addr_b), bus.ind_b));
      chk("rand_addr_w", bus.w_addr, ref_addr(int'(bus.l_w_addr), bus.ind_w));

      n_sr = m_sr;
      if (bus.sr_we) n_sr = int'(bus.sr_wdata);
      else if (bus.sr_inc && !bus.sr_dec) n_sr = (m_sr + 1) % 16;
      else if (bus.sr_dec && !bus.sr_inc) n_sr = (m_sr + 15) % 16;
      n_ptr = m_ptr; n_lo = m_lo; n_hi = m_hi; n_wrap = 0;
      if (bus.ptr_we && bus.ptr_sel == 2'd0) n_ptr = int'(bus.ptr_wdata);
      else if (bus.ptr_step) begin
        if (m_ptr == m_hi) begin n_ptr = m_lo; n_wrap = 1; end
        else n_ptr = (m_ptr + 1) % 128;
      end
      if (bus.ptr_we && bus.ptr_sel == 2'd1) n_lo = int'(bus.ptr_wdata);
      if (bus.ptr_we && bus.ptr_sel == 2'd2) n_hi = int'(bus.ptr_wdata);

      @(posedge clk);
      #1;
      m_sr = n_sr; m_ptr = n_ptr; m_lo = n_lo; m_hi = n_hi; m_wrap = n_wrap;
      chk("rand_sr", bus.sr_value, m_sr);
      chk("rand_ptr", bus.ptr_value, m_ptr);
      chk("rand_wrap", bus.ptr_wrap, m_wrap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/banked_address_generation_unit.md
BANKED_ADDRESS_GENERATION_UNIT -- requirements
Module: banked_address_generation_unit

Interface
REQ-001 Parameter ADDR, default 7: width of every generated physical address.
REQ-002 Parameter LADDR, default 4: width of a local address field; MSB is the bank-select bit; OFS = LADDR-1 offset bits; SEGW = ADDR-OFS segment bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 l_r_addr_a, l_r_addr_b, l_w_addr  input  LADDR each  local addresses for read ports A and B and the write port.
REQ-006 ind_a, ind_b, ind_w  input  1 each  per-port indirect select; 1 = address taken from the pointer register.
REQ-007 sr_we  input  1; sr_wdata  input  SEGW; sr_inc  input  1; sr_dec  input  1  segment register controls.
REQ-008 ptr_we  input  1; ptr_sel  input  2 (0=ptr, 1=lo, 2=hi, 3=reserved); ptr_wdata  input  ADDR  pointer/window load.
REQ-009 ptr_step  input  1  post-increment request for the pointer.
REQ-010 r_addr_a, r_addr_b, w_addr  output  ADDR each  physical addresses.
REQ-011 sr_value  output  SEGW  current segment register.
REQ-012 ptr_value  output  ADDR  current pointer register.
REQ-013 ptr_wrap  output  1  registered one-cycle pulse, high in the cycle after a window wrap.

Function
REQ-014 Direct mode (ind_x=0), bank bit 1: address = {sr_value, offset}; bank bit 0: address = {SEGW zeros, offset}.
REQ-015 Indirect mode (ind_x=1): address = ptr_value; the local field is ignored.
REQ-016 Address outputs are combinational from inputs and current registers: zero-cycle latency; register writes become visible one cycle after the edge.
REQ-017 Segment register update priority: sr_we (load sr_wdata) > sr_inc xor sr_dec (+/-1, modulo 2^SEGW) > hold; sr_inc and sr_dec together without sr_we = hold.
REQ-018 Segment increment from all-ones wraps to 0; decrement from 0 wraps to all-ones; no flag.
REQ-019 ptr_we with ptr_sel 0/1/2 loads ptr/lo/hi from ptr_wdata; ptr_sel 3 = no effect.
REQ-020 ptr_step without ptr_we(ptr_sel=0): if ptr == hi then ptr <= lo and ptr_wrap pulses next cycle, else ptr <= ptr+1 modulo 2^ADDR.
REQ-021 ptr_we with ptr_sel=0 and ptr_step in the same cycle: load wins, step discarded, no ptr_wrap.
REQ-022 ptr_step in the same cycle as a lo or hi load: step evaluated against the old lo/hi values.
REQ-023 Window comparison is equality only; ptr above hi or lo > hi gives no error, ptr increments and wraps at 2^ADDR to 0 without ptr_wrap.
REQ-024 Indirect reads and writes in the step cycle use the pre-step pointer (post-increment).

Reset
REQ-025 Asserting reset asynchronously sets sr=0, ptr=0, lo=0, hi=all ones, ptr_wrap=0, regardless of clk.
REQ-026 During reset all address outputs follow REQ-014/015 using reset register values; a ptr_wrap pending at reset assertion is dropped.
REQ-027 First state update occurs on the first rising clk edge after reset deasserts.

Structure
REQ-028 Package agu_pkg holds defaults for ADDR/LADDR, derived OFS/SEGW functions, and PTR_SEL_PTR/LO/HI/RSV constants.
REQ-029 One sub-module, agu_port_mux (local field, ind, sr, ptr -> ADDR address), instantiated three times; segment and pointer logic stay in the top module.

Verification
REQ-030 Reset, then l_r_addr_a=4'hB, ind_a=0 -> r_addr_a=7'h03; l_w_addr=4'h5 -> w_addr=7'h05.
REQ-031 sr_we=1, sr_wdata=4'hA, one cycle; then l_r_addr_b=4'hE -> r_addr_b=7'h56; sr_inc and sr_dec together next cycle -> sr_value stays 4'hA.
REQ-032 sr=4'hF, sr_inc one cycle -> sr_value=4'h0; sr_dec one cycle -> 4'hF.
REQ-033 lo=7'h10, hi=7'h12, ptr=7'h10; ind_w=1, ptr_step for 3 cycles -> w_addr 10,11,12, then ptr=7'h10 and ptr_wrap high exactly one cycle.
REQ-034 ptr_we(ptr_sel=0, 7'h40) with ptr_step same cycle -> ptr_value=7'h40, ptr_wrap=0; ptr=7'h7F, hi=7'h12, step -> ptr=7'h00, no wrap.
REQ-035 Assert reset mid-sequence with sr=4'h3, ptr=7'h11 -> immediately sr_value=0, ptr_value=0, ptr_wrap=0 without a clk edge.
